stream_mux_rr: RTL and testbench
================================

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 SHALL have parameter W, default 8: data width per channel, at least 1.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  N_CH*W: channel i occupies bits [i*W +: W].
REQ-006 SHALL have port in_valid  input  N_CH: per-channel valid.
REQ-007 SHALL have port in_last  input  N_CH: per-channel end-of-packet flag.
REQ-008 SHALL have port in_ready  output  N_CH: per-channel accept.
REQ-009 SHALL have port out_data  output  W: registered selected data.
REQ-010 SHALL have port out_ch  output  CW = max(1, clog2(N_CH)): source channel index of out_data.
REQ-011 SHALL have port out_last  output  1: registered in_last of the accepted beat.
REQ-012 SHALL have port out_valid  output  1: output holds a beat.
REQ-013 SHALL have port out_ready  input  1: downstream accept.

Function
REQ-014 SHALL assert load = !out_valid || out_ready; a beat is accepted only when load is high.
REQ-015 SHALL transfer an input beat on channel i only when in_valid[i] && in_ready[i]; an output beat transfers when out_valid && out_ready.
REQ-016 SHALL grant round-robin: search starts at ptr+1 (mod N_CH), and the first channel with in_valid high wins.
REQ-017 SHALL drive in_ready[i] high only for the granted channel and only while load is high; at most one in_ready bit is high per cycle.
REQ-018 SHALL compute the grant combinationally from in_valid and ptr; in_ready SHALL NOT depend on in_data.
REQ-019 SHALL, on acceptance, register data, channel index and last into out_data, out_ch and out_last, set out_valid, and set ptr to the granted index.
REQ-020 SHALL have a latency of 1 cycle from acceptance to out_valid, and a throughput of 1 beat per cycle while out_ready stays high.
REQ-021 SHALL hold out_data, out_ch, out_last and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid on an output transfer when no input beat is accepted in the same cycle; a simultaneous output transfer and input acceptance SHALL reload the register with no bubble.
REQ-023 SHALL leave ptr unchanged when no channel is valid.
REQ-024 SHALL keep ptr wrap-around exact for non-power-of-two N_CH: index N_CH-1 is followed by index 0.

Reset
REQ-025 SHALL, while rst_n is low, force out_valid=0, out_data=0, out_ch=0, out_last=0 and ptr=N_CH-1, so that channel 0 has first priority, and clear the lock state.
REQ-026 SHALL drop any beat held in the output register when reset is asserted mid-transfer; no beat SHALL be accepted during the first cycle after rst_n rises.

Configuration
REQ-027 SHALL, when PKT_LOCK_EN is defined, lock the grant to a channel after it delivers an accepted beat with in_last=0, and keep it locked until a beat with in_last=1 is accepted; other channels SHALL see in_ready=0 while locked, even if the locked channel is idle.
REQ-028 SHALL, when PKT_LOCK_EN is undefined, arbitrate per beat, pass in_last through to out_last only, and include no lock register.

Structure
REQ-029 SHALL place shared constants in package stream_mux_pkg: the CW width function and the channel index typedef.
REQ-030 SHALL implement the grant logic in sub-module rr_arbiter, with inputs req[N_CH] and ptr and a one-hot grant output; the output register and lock logic remain in stream_mux_rr.

Verification
REQ-031 SHALL cover: reset, then in_valid=4'b1111, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-032 SHALL cover: in_valid=4'b0100 only, in_data[2]=8'hA5 -> out_data=8'hA5 and out_ch=2 one cycle after in_ready[2] is high.
REQ-033 SHALL cover: output beat pending with out_ready=0 for 3 cycles -> outputs stable and all in_ready=0; then out_ready=1 -> back-to-back beats with no bubble.
REQ-034 SHALL cover: PKT_LOCK_EN defined, channel 1 sends 3 beats with last on the third while channel 0 is valid throughout -> output channels 1,1,1, then 0.
REQ-035 SHALL cover: rst_n dropped asynchronously while out_valid=1 -> out_valid=0 immediately; after release, the first grant goes to the lowest valid channel.
REQ-036 SHALL cover: N_CH=3 with all channels valid -> out_ch sequence 0,1,2,0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and helpers for the round-robin stream mux
//
// Purpose : width helper for the channel-index field and the channel index type
//           used by stream_mux_rr and rr_arbiter.
// Contents: MAX_CH, MAX_CW  - upper bound on channel count and its index width
//           ch_idx_t        - channel index wide enough for any legal N_CH
//           cw_of(n)        - index width for n channels, never below 1 bit

package stream_mux_pkg;

  localparam int MAX_CH = 16;
  localparam int MAX_CW = 4;

  typedef logic [MAX_CW-1:0] ch_idx_t;

  // A 2-channel mux still needs a 1-bit index, so the width is floored at 1.
  function automatic int cw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant for the stream mux
//
// Purpose : picks the first requesting channel at or after ptr+1, wrapping
//           from N_CH-1 back to 0 even when N_CH is not a power of two.
// Ports   : req   [N_CH-1]  per-channel request (already lock-filtered)
//           ptr   [CW-1]    index of the most recently granted channel
//           grant [N_CH-1]  one-hot grant, all zero when nothing requests

module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [cw_of(N_CH)-1:0]  ptr,
  output logic [N_CH-1:0]         grant
);

  localparam int CW = cw_of(N_CH);

  // One extra bit so ptr + k (at most 2*N_CH-1) never overflows before the
  // explicit modulo subtraction.
  logic [CW:0] cand;
  logic        found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = {1'b0, ptr} + (CW+1)'(k);
      if (cand >= (CW+1)'(N_CH)) begin
        cand = cand - (CW+1)'(N_CH);
      end
      if (!found && req[cand[CW-1:0]]) begin
        grant[cand[CW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel round-robin stream multiplexer with registered output
//
// Purpose : merges N_CH valid/ready input streams into one output stream.
//           The grant rotates round-robin; the output is a single register
//           stage that reloads without a bubble when drained and refilled in
//           the same cycle.
// Ports   : clk, rst_n                 clock, async active-low reset
//           in_data  [N_CH*W-1]        channel i at bits [i*W +: W]
//           in_valid/in_last [N_CH-1]  per-channel valid and end-of-packet
//           in_ready [N_CH-1]          per-channel accept, at most one high
//           out_data [W-1], out_ch [CW-1], out_last, out_valid  registered beat
//           out_ready                  downstream accept
// Options : PKT_LOCK_EN - when defined, a channel that starts a packet keeps
//           the grant until it delivers its in_last beat.

module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH*W-1:0]       in_data,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH-1:0]         in_last,
  output logic [N_CH-1:0]         in_ready,
  output logic [W-1:0]            out_data,
  output logic [cw_of(N_CH)-1:0]  out_ch,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int      CW      = cw_of(N_CH);
  localparam ch_idx_t LAST_CH = ch_idx_t'(N_CH - 1);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]   out_ch_q,   out_ch_d;
  logic            out_last_q, out_last_d;
  logic            out_valid_q, out_valid_d;
  logic [CW-1:0]   ptr_q,      ptr_d;
  // Low through reset and the first cycle after release, so nothing is
  // accepted until the flops have seen one clean edge.
  logic            init_q,     init_d;

  logic            load;
  logic            accept;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] grant;
  logic [CW-1:0]   gnt_idx;
  logic [W-1:0]    gnt_data;
  logic            gnt_last;

`ifdef PKT_LOCK_EN
  logic            lock_q,    lock_d;
  logic [CW-1:0]   lock_ch_q, lock_ch_d;

  // While locked only the owning channel may request, even if it is idle.
  always_comb begin
    req = in_valid;
    if (lock_q) begin
      req = in_valid & (N_CH'(1) << lock_ch_q);
    end
  end
`else
  assign req = in_valid;
`endif

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant)
  );

  assign load     = !out_valid_q || out_ready;
  assign accept   = load && init_q && (|grant);
  assign in_ready = (load && init_q) ? grant : '0;

  // AND-OR select driven by the one-hot grant; in_ready never sees in_data.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = gnt_idx | CW'(i);
        gnt_data = gnt_data | in_data[i*W +: W];
      end
    end
    gnt_last = |(grant & in_last);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    init_d      = 1'b1;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_last_d  = gnt_last;
      ptr_d       = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef PKT_LOCK_EN
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (accept) begin
      lock_d    = !gnt_last;
      lock_ch_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  // ptr resets to the last channel so the first search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      ptr_q       <= LAST_CH[CW-1:0];
      init_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
      init_q      <= init_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (4-channel model plus 3-channel directed run)

module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  logic        rst3_n;
  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_last;
  logic [2:0]  d3_in_ready;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_ch;
  logic        d3_out_last;
  logic        d3_out_valid;
  logic        d3_out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  stream_mux_rr #(.N_CH(3), .W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst3_n),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_last   (d3_in_last),
    .in_ready  (d3_in_ready),
    .out_data  (d3_out_data),
    .out_ch    (d3_out_ch),
    .out_last  (d3_out_last),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output register contents, last granted index, packet lock.
  int         m_ptr;
  bit         m_ov;
  logic [7:0] m_data;
  int         m_ch;
  bit         m_last;
  bit         m_init;
  bit         m_lock;
  int         m_lock_ch;

  always @(negedge clk) begin
    int         g;
    logic [3:0] exp_rdy;
    if (!rst_n) begin
      m_ptr  = 3;
      m_ov   = 0;
      m_data = 8'h00;
      m_ch   = 0;
      m_last = 0;
      m_init = 0;
      m_lock = 0;
    end
    g = -1;
    if (rst_n && m_init && (!m_ov || out_ready)) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (g < 0 && in_valid[c] && (!m_lock || c == m_lock_ch)) g = c;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("mdl_in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov || !rst_n) begin
      chk("mdl_out_data", 32'(out_data), 32'(m_data));
      chk("mdl_out_ch", 32'(out_ch), 32'(m_ch));
      chk("mdl_out_last", 32'(out_last), 32'(m_last));
    end
    if (rst_n) begin
      if (g >= 0) begin
        m_ov   = 1;
        m_data = 8'(in_data >> (8 * g));
        m_ch   = g;
        m_last = in_last[g];
        m_ptr  = g;
`ifdef PKT_LOCK_EN
        m_lock    = !in_last[g];
        m_lock_ch = g;
`endif
      end else if (out_ready) begin
        m_ov = 0;
      end
      m_init = 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    int seq4[5];
    int seq3[4];
    int n;
    seq4 = '{0, 1, 2, 3, 0};
    seq3 = '{0, 1, 2, 0};

    rst_n = 1'b0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b0;
    rst3_n = 1'b0; d3_in_data = 24'h221100; d3_in_valid = 3'b111;
    d3_in_last = 3'b111; d3_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_in_ready", 32'(in_ready), 0);

    // All four channels valid: rotation 0,1,2,3,0 with no gaps.
    in_valid = 4'hF; in_last = 4'hF; in_data = 32'h33221100; out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("first_cycle_no_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("first_grant_ch0", 32'(in_ready), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rr4_valid", 32'(out_valid), 1);
      chk("rr4_ch", 32'(out_ch), 32'(seq4[i]));
      chk("rr4_data", 32'(out_data), 32'(seq4[i] * 8'h11));
    end

    // Single channel 2 with 0xA5.
    in_valid = 4'b0100; in_data = 32'h00A50000;
    #1;
    n = 0;
    while (!in_ready[2] && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("a5_ready_seen", 32'(in_ready[2]), 1);
    @(posedge clk); #1;
    chk("a5_valid", 32'(out_valid), 1);
    chk("a5_data", 32'(out_data), 32'hA5);
    chk("a5_ch", 32'(out_ch), 2);

    // Downstream stall for 3 cycles, then back-to-back drain.
    out_ready = 1'b0; in_valid = 4'b0011; in_data = 32'h00001110;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'hA5);
      chk("stall_ch", 32'(out_ch), 2);
      chk("stall_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_ch", 32'(out_ch), 32'(i % 2));
      chk("drain_data", 32'(out_data), 32'(8'h10 + (i % 2)));
    end

    // Asynchronous reset while a beat is held.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 0);
    in_valid = 4'b1110;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_no_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("post_rst_grant", 32'(in_ready), 32'h2);
    @(posedge clk); #1;
    chk("post_rst_ch", 32'(out_ch), 1);
    chk("post_rst_data", 32'(out_data), 32'h11);

`ifdef PKT_LOCK_EN
    // Channel 1 packet of three beats while channel 0 stays valid.
    in_valid = 4'b0001; in_last = 4'b0001; in_data = 32'h00002120;
    @(posedge clk); #1;
    chk("lock_pre_ch", 32'(out_ch), 0);
    in_valid = 4'b0011;
    @(posedge clk); #1;
    chk("lock_b0_ch", 32'(out_ch), 1);
    @(posedge clk); #1;
    chk("lock_b1_ch", 32'(out_ch), 1);
    in_last = 4'b0011;
    @(posedge clk); #1;
    chk("lock_b2_ch", 32'(out_ch), 1);
    chk("lock_b2_last", 32'(out_last), 1);
    @(posedge clk); #1;
    chk("lock_after_ch", 32'(out_ch), 0);
`endif

    // Three-channel instance: wrap from 2 back to 0.
    rst3_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rr3_valid", 32'(d3_out_valid), 1);
      chk("rr3_ch", 32'(d3_out_ch), 32'(seq3[i]));
    end

    // Randomized traffic, backpressure and occasional resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
